// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared constants, FSM encoding and helpers for the BCD converter
// Contents:
//   DIGIT_W  : bits per BCD digit
//   BCD_NINE : saturated digit value
//   state_t  : converter FSM encoding (IDLE/SHIFT/DONE)
//   pow10(n) : constant function 10**n, used for the saturation threshold
package bcd_pkg;

  localparam int DIGIT_W = 4;
  localparam logic [3:0] BCD_NINE = 4'd9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // 10**10 still fits comfortably in 64 bits, which covers the full DIGITS range.
  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) begin
      r = r * 64'd10;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// rtl/bcd_digit_adj.sv - double-dabble digit correction: add 3 when digit >= 5
// Ports:
//   din  in  DIGIT_W  scratch digit before the shift
//   dout out DIGIT_W  corrected digit, ready to be shifted left
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] din,
  output logic [DIGIT_W-1:0] dout
);

  assign dout = (din >= 4'd5) ? (din + 4'd3) : din;

endmodule

// File: rtl/bcd_cvt_seq.sv
// rtl/bcd_cvt_seq.sv - sequential binary-to-BCD converter (one bit per clock) with saturation
// Ports:
//   clk      in  1           system clock, rising edge
//   rst      in  1           synchronous active-high reset
//   start    in  1           conversion request, accepted while ready=1
//   data_in  in  WIDTH       unsigned value, sampled on the accepting edge
//   ready    out 1           idle, start will be accepted
//   valid    out 1           one-cycle pulse when bcd/lz_mask/overflow update
//   bcd      out 4*DIGITS    result digits, digit 0 in the low nibble
//   lz_mask  out DIGITS      bit i set when digit i and all higher digits are zero (bit 0 always 0)
//   overflow out 1           last result saturated to all nines
module bcd_cvt_seq
  import bcd_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [WIDTH-1:0]           data_in,
  output logic                       ready,
  output logic                       valid,
  output logic [DIGIT_W*DIGITS-1:0]  bcd,
  output logic [DIGITS-1:0]          lz_mask,
  output logic                       overflow
);

  localparam int BCD_W = DIGIT_W * DIGITS;
  // One extra bit over the BCD width keeps 10**DIGITS-1 representable for every DIGITS.
  localparam int CMP_W = (WIDTH > BCD_W + 1) ? WIDTH : (BCD_W + 1);
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CMP_W-1:0] LIMIT = CMP_W'(pow10(DIGITS) - 64'd1);
  localparam logic [DIGITS-1:0] LZ_RST = {DIGITS{1'b1}} ^ DIGITS'(1);

  state_t             state;
  state_t             state_nxt;
  logic               accept;
  logic               finish;

  logic [WIDTH-1:0]   shift_reg;
  logic [BCD_W-1:0]   scratch;
  logic [BCD_W-1:0]   scratch_adj;
  logic [CNT_W-1:0]   cnt;
  logic               ovf_lat;

  logic [CMP_W-1:0]   data_ext;
  logic               ovf_cmp;
  logic [DIGITS-1:0]  lz_nxt;
  logic               zero_above;

  // Per-digit correction applied before every shift.
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .din  (scratch[g*DIGIT_W +: DIGIT_W]),
      .dout (scratch_adj[g*DIGIT_W +: DIGIT_W])
    );
  end

  // When 10**DIGITS exceeds the input range this folds to constant 0.
  assign data_ext = CMP_W'(data_in);
  assign ovf_cmp  = (data_ext > LIMIT);

  // Leading-zero blanking: walk from the top digit down, staying set while digits are zero.
  always_comb begin
    lz_nxt     = '0;
    zero_above = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_above = zero_above && (scratch[i*DIGIT_W +: DIGIT_W] == 4'd0);
      lz_nxt[i]  = zero_above;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt == CNT_W'(1)) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        finish    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_reg <= '0;
      scratch   <= '0;
      cnt       <= '0;
      ovf_lat   <= 1'b0;
      ready     <= 1'b1;
      valid     <= 1'b0;
      bcd       <= '0;
      lz_mask   <= LZ_RST;
      overflow  <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (accept) begin
        shift_reg <= data_in;
        scratch   <= '0;
        cnt       <= CNT_W'(WIDTH);
        ovf_lat   <= ovf_cmp;
        ready     <= 1'b0;
      end else if (state == SHIFT) begin
        {scratch, shift_reg} <= {scratch_adj, shift_reg} << 1;
        cnt                  <= cnt - 1'b1;
      end else if (finish) begin
        valid <= 1'b1;
        ready <= 1'b1;
        if (ovf_lat) begin
          bcd      <= {DIGITS{BCD_NINE}};
          lz_mask  <= '0;
          overflow <= 1'b1;
        end else begin
          bcd      <= scratch;
          lz_mask  <= lz_nxt;
          overflow <= 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/bcd_cvt_seq.md
Name: bcd_cvt_seq

Overview:
- Sequential binary-to-BCD converter, parametrised in input width and output digit count.
- Uses iterative shift-and-add-3 (double dabble): one input bit per clock, with a start/ready/valid handshake.
- Adds saturation on overflow and a leading-zero mask for display blanking.
- Sits between game-state counters (score, timer, health) and the 7-segment/VGA digit renderers. Supersedes the fixed 2-digit, 0..99 converter.

Parameters:
- WIDTH, 16, binary input width in bits (range 4..32).
- DIGITS, 5, number of BCD output digits (range 1..10).

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  reset, synchronous and active-high.
- start  in  1  request conversion of data_in; accepted only when ready=1.
- data_in  in  WIDTH  unsigned binary value, sampled on the accepting edge.
- ready  out  1  converter idle; can accept start.
- valid  out  1  one-cycle pulse: bcd/lz_mask/overflow updated this cycle.
- bcd  out  4*DIGITS  result; digit i occupies bits [4i+3:4i], digit 0 least significant.
- lz_mask  out  DIGITS  bit i=1 when digit i and every higher digit are 0 (i>=1); bit 0 always 0.
- overflow  out  1  last result saturated (input > 10^DIGITS-1).

Behaviour:
- Reset values:
  - ready=1, valid=0, bcd=0, overflow=0.
  - lz_mask = all ones except bit 0.
  - FSM in IDLE; internal shift/scratch registers cleared.
- FSM states IDLE, SHIFT, DONE.
  - IDLE: if start, latch data_in into the shift register, clear the BCD scratch, latch the overflow compare, load the bit counter with WIDTH, go to SHIFT, ready<=0.
  - SHIFT: each cycle, add 3 to every scratch digit >=5, then shift {scratch, shift_reg} left by 1 and decrement the counter. After the WIDTH-th shift go to DONE.
  - DONE (one cycle): register bcd, lz_mask, overflow, valid<=1, ready<=1, go to IDLE.
- Latency: the accepting edge is E0. valid is high in the cycle after edge E0+WIDTH+1, i.e. a fixed WIDTH+2 cycles from the start cycle to the valid cycle. It is independent of data value.
- Back-to-back:
  - ready is high in the same cycle as valid.
  - A start presented in the valid cycle is accepted, giving a throughput of one conversion per WIDTH+2 cycles.
- start while ready=0 is ignored. No queuing, no error flag.
- data_in is used only on the accepting edge; later changes have no effect on the conversion in flight.
- Outputs bcd/lz_mask/overflow hold their values between valid pulses.
- Overflow:
  - Compare data_in > 10^DIGITS-1 at accept, in max(WIDTH, 4*DIGITS+1)-bit arithmetic.
  - If true, DONE drives every digit = 9, overflow=1, lz_mask = 0.
  - If 10^DIGITS > 2^WIDTH-1, overflow is constant 0; synthesis prunes the compare.
- Scratch digits wider than needed stay 0. No digit ever exceeds 9 on output.
- Reset mid-conversion aborts immediately. All outputs take reset values on the next edge, and no valid pulse is emitted for the aborted request.
- rst and start high together: rst wins; nothing is accepted.
- Input 0: bcd=0, lz_mask all ones except bit 0, overflow=0.

Decomposition:
- Package bcd_pkg holds:
  - constant function pow10(n), used for the saturation threshold;
  - localparam DIGIT_W=4;
  - localparam BCD_NINE=4'd9;
  - the FSM state encoding (IDLE/SHIFT/DONE, 2-bit).
- Sub-module bcd_digit_adj: combinational 4-bit "if >=5 add 3", instantiated DIGITS times via generate.
- The top-level holds the FSM, counter, shift registers, overflow compare and lz_mask derivation.

Test Plan:
- WIDTH=16, DIGITS=5, data_in=0, start 1 cycle -> valid exactly 18 cycles after the start cycle (WIDTH+2); bcd=0x00000; lz_mask=5'b11110; overflow=0.
- WIDTH=16, DIGITS=5, data_in=65535 -> bcd=0x65535, lz_mask=0, overflow=0; then data_in=99 -> bcd=0x00099, lz_mask=5'b11100.
- WIDTH=16, DIGITS=4, data_in=12345 -> bcd=0x9999, overflow=1, lz_mask=0. Next conversion of 9999 -> bcd=0x9999, overflow=0.
- Back-to-back: start=1 with 42, then start=1 with 7 in the valid cycle -> two valid pulses 18 cycles apart; results 0x00042 then 0x00007. A start asserted mid-conversion with 500 is ignored: no third pulse.
- Reset mid-conversion: start with 1234, assert rst at cycle 8 for 1 cycle -> no valid pulse, bcd=0, ready=1 next cycle. A new start with 56 -> bcd=0x00056.
- WIDTH=7, DIGITS=2 sweep 0..127 vs a reference model -> 0..99 exact; 100..127 -> bcd=0x99, overflow=1.
